// File: rtl/bus_dma.sv
// Byte-copy DMA initiator on the shared 8-bit data / 16-bit address bus.
// Each byte is one read, a one-cycle gap, one write and another one-cycle gap.
module bus_dma (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] src_addr,
   input  logic [15:0] dst_addr,
   input  logic [7:0]  length,
   output logic        busy,
   output logic        done,
   output logic [15:0] bus_address_out,
   output logic [7:0]  bus_data_out,
   input  logic [7:0]  bus_data_in,
   output logic        bus_read,
   output logic        bus_write,
   input  logic        bus_wait
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD     = 3'd1,
      S_RD_GAP = 3'd2,
      S_WR     = 3'd3,
      S_WR_GAP = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [15:0] src_q;
   logic [15:0] dst_q;
   logic [7:0]  cnt_q;
   logic [7:0]  byte_q;

   // Bus handshake: bus_read/bus_write is a level request held with constant
   // address/data until a cycle where bus_wait=0, which completes the transfer
   // at that clock edge. bus_wait is ignored when no request is raised.

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_q  <= 16'h0000;
         dst_q  <= 16'h0000;
         cnt_q  <= 8'h00;
         byte_q <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  src_q <= src_addr;
                  dst_q <= dst_addr;
                  cnt_q <= length;
               end
            end
            S_RD: begin
               if (!bus_wait) begin
                  byte_q <= bus_data_in;
               end
            end
            S_WR_GAP: begin
               // 16-bit adds wrap naturally at 16'hFFFF
               src_q <= src_q + 16'd1;
               dst_q <= dst_q + 16'd1;
               cnt_q <= cnt_q - 8'd1;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (length != 8'd0) ? S_RD : S_FIN;
            end
         end
         S_RD: begin
            if (!bus_wait) begin
               state_d = S_RD_GAP;
            end
         end
         S_RD_GAP: state_d = S_WR;
         S_WR: begin
            if (!bus_wait) begin
               state_d = S_WR_GAP;
            end
         end
         // cnt_q still holds the pre-decrement count here
         S_WR_GAP: state_d = (cnt_q != 8'd1) ? S_RD : S_FIN;
         S_FIN:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy            = 1'b0;
      done            = 1'b0;
      bus_read        = 1'b0;
      bus_write       = 1'b0;
      bus_address_out = 16'h0000;
      bus_data_out    = 8'h00;
      case (state_q)
         S_IDLE: begin
         end
         S_RD: begin
            busy            = 1'b1;
            bus_read        = 1'b1;
            bus_address_out = src_q;
         end
         S_WR: begin
            busy            = 1'b1;
            bus_write       = 1'b1;
            bus_address_out = dst_q;
            bus_data_out    = byte_q;
         end
         S_FIN: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: a memory responder with wait-state control,
// a table of copy scenarios and hand-written reset sequences.
module tb_bus_dma;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] src_addr;
   logic [15:0] dst_addr;
   logic [7:0]  length;
   logic        busy;
   logic        done;
   logic [15:0] bus_address_out;
   logic [7:0]  bus_data_out;
   logic [7:0]  bus_data_in;
   logic        bus_read;
   logic        bus_write;
   logic        bus_wait;

   bus_dma dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .src_addr        (src_addr),
      .dst_addr        (dst_addr),
      .length          (length),
      .busy            (busy),
      .done            (done),
      .bus_address_out (bus_address_out),
      .bus_data_out    (bus_data_out),
      .bus_data_in     (bus_data_in),
      .bus_read        (bus_read),
      .bus_write       (bus_write),
      .bus_wait        (bus_wait)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:65535];
   logic [23:0] exp_q[$];
   logic [15:0] exp_rd_q[$];
   int          act_cnt = 0;
   int          stretch_need = 1;
   logic        stretch_arm = 1'b0;

   typedef struct {
      logic [15:0] src;
      logic [15:0] dst;
      logic [7:0]  len;
      int          need;
      int          inj_cyc;
      int          exp_done;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Responder and monitor, all on the falling edge
   int          age = 0;
   int          need = 1;
   logic        held = 1'b0;
   logic [41:0] prev_bus;
   initial begin
      bus_wait    = 1'b1;
      bus_data_in = 8'h00;
   end
   always @(negedge clk) begin
      if (bus_read || bus_write) begin
         act_cnt++;
         chk("rd_wr_exclusive", {30'd0, bus_read, bus_write} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
         if (held) begin
            checks++;
            if ({bus_read, bus_write, bus_address_out, bus_data_out, 16'h0} !== prev_bus) begin
               errors++;
               $display("FAIL stable_hold: got %0h expected %0h",
                        {bus_read, bus_write, bus_address_out, bus_data_out}, prev_bus[41:16]);
            end
         end
         if (age == 0) begin
            need = (bus_read && stretch_arm) ? stretch_need : 1;
            if (bus_read) stretch_arm = 1'b0;
         end
         bus_wait    = (age < need);
         bus_data_in = bus_read ? mem[bus_address_out] : 8'h00;
         if (!bus_wait) begin
            if (bus_read) begin
               if (exp_rd_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_read: got %0h expected none", bus_address_out);
               end else begin
                  chk("read_addr", {16'd0, bus_address_out}, {16'd0, exp_rd_q.pop_front()});
               end
            end else begin
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write: got %0h expected none",
                           {bus_address_out, bus_data_out});
               end else begin
                  chk("write_addr_data", {8'd0, bus_address_out, bus_data_out},
                      {8'd0, exp_q.pop_front()});
               end
               mem[bus_address_out] = bus_data_out;
            end
            age  = 0;
            held = 1'b0;
         end else begin
            age++;
            held     = 1'b1;
            prev_bus = {bus_read, bus_write, bus_address_out, bus_data_out, 16'h0};
         end
      end else begin
         bus_wait    = 1'($urandom_range(0, 1));
         bus_data_in = 8'($urandom_range(0, 255));
         age         = 0;
         held        = 1'b0;
      end
   end

   task automatic run_vec(input int idx, input vec_t v);
      logic [7:0]  ov [int];
      logic [15:0] s;
      logic [15:0] d;
      logic [7:0]  b;
      int done_cyc = -1;
      int done_cnt = 0;
      int busy_cnt = 0;
      int act_base;
      int limit;
      s = v.src;
      d = v.dst;
      for (int i = 0; i < int'(v.len); i++) begin
         b = ov.exists(int'(s)) ? ov[int'(s)] : mem[s];
         ov[int'(d)] = b;
         exp_rd_q.push_back(s);
         exp_q.push_back({d, b});
         s = s + 16'd1;
         d = d + 16'd1;
      end
      stretch_need = v.need;
      stretch_arm  = 1'b1;
      act_base     = act_cnt;
      limit        = v.exp_done + v.need + 40;
      @(negedge clk);
      start    = 1'b1;
      src_addr = v.src;
      dst_addr = v.dst;
      length   = v.len;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         @(negedge clk);
         start    = (cyc == v.inj_cyc);
         src_addr = 16'h0000;
         dst_addr = 16'h0700;
         length   = 8'd5;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 8) break;
      end
      start = 1'b0;
      if (done_cyc < 0) begin
         errors++;
         checks++;
         $display("FAIL vec%0d_timeout: got no done expected done at %0d", idx, v.exp_done);
      end else begin
         chk($sformatf("vec%0d_done_cycle", idx), done_cyc, v.exp_done);
      end
      chk($sformatf("vec%0d_done_pulses", idx), done_cnt, 1);
      chk($sformatf("vec%0d_busy_cycles", idx), busy_cnt, v.exp_done);
      chk($sformatf("vec%0d_writes_left", idx), exp_q.size(), 0);
      chk($sformatf("vec%0d_reads_left", idx), exp_rd_q.size(), 0);
      if (v.len == 8'd0) chk($sformatf("vec%0d_no_bus_activity", idx), act_cnt - act_base, 0);
      exp_q.delete();
      exp_rd_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcnt;
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8) ^ 8'h47);
      mem[16'h0100] = 8'h3E;
      mem[16'h0101] = 8'h03;
      mem[16'h0102] = 8'h26;
      mem[16'h0400] = 8'hA5;
      mem[16'hFFFF] = 8'h5A;
      mem[16'h0000] = 8'hC3;

      vecs[0] = '{16'h0100, 16'h0200, 8'd3, 1, 0,  19};
      vecs[1] = '{16'h1234, 16'h5678, 8'd0, 1, 0,  1};
      vecs[2] = '{16'hFFFF, 16'h7FFF, 8'd2, 1, 0,  13};
      vecs[3] = '{16'h0100, 16'h0300, 8'd3, 5, 0,  23};
      vecs[4] = '{16'h0400, 16'h0401, 8'd3, 1, 0,  19};
      vecs[5] = '{16'h0500, 16'h0600, 8'd2, 1, 3,  13};
      vecs[6] = '{16'h0500, 16'h0800, 8'd2, 1, 13, 13};
      vecs[7] = '{16'h8000, 16'h0000, 8'd1, 1, 0,  7};

      // Reset state
      rst_n    = 1'b0;
      start    = 1'b1;
      src_addr = 16'h1111;
      dst_addr = 16'h2222;
      length   = 8'd4;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_req", {bus_read, bus_write}, 0);
      chk("reset_addr_data", {bus_address_out, bus_data_out}, 0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 0);

      // Reset while the first write request is held
      exp_rd_q.push_back(16'h0100);
      stretch_arm = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      src_addr = 16'h0100;
      dst_addr = 16'h0900;
      length   = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_in_wr", {bus_write, bus_address_out, bus_data_out}, {1'b1, 16'h0900, 8'h3E});
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_write_dropped", bus_write, 0);
      chk("abort_busy", busy, 0);
      chk("abort_outputs", {bus_read, done, bus_address_out, bus_data_out}, 0);
      rst_n = 1'b1;
      dcnt  = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);
      chk("abort_reads_left", exp_rd_q.size(), 0);
      chk("abort_mem_untouched", mem[16'h0900], 8'(16'h0900 ^ 16'h0009 ^ 16'h0047));
      exp_rd_q.delete();

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      chk("copy_0200", {mem[16'h0200], mem[16'h0201], mem[16'h0202]}, 24'h3E0326);
      chk("stretch_0300", {mem[16'h0300], mem[16'h0301], mem[16'h0302]}, 24'h3E0326);
      chk("overlap_0401", {mem[16'h0401], mem[16'h0402], mem[16'h0403]}, 24'hA5A5A5);
      chk("wrap_dst", {mem[16'h7FFF], mem[16'h8000]}, 16'h5AC3);
      chk("ignored_start_dst", mem[16'h0700], 8'(16'h0700 ^ 16'h0007 ^ 16'h0047));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin a copy; sampled only in IDLE.
REQ-005 src_addr  input  16  first source byte address; captured on accepted start.
REQ-006 dst_addr  input  16  first destination byte address; captured on accepted start.
REQ-007 length  input  8  byte count; captured on accepted start; 0 means no transfer.
REQ-008 busy  output  1  high from the cycle after an accepted start until done is pulsed.
REQ-009 done  output  1  one-cycle pulse when a copy finishes.
REQ-010 bus_address_out  output  16  bus address; valid whenever bus_read or bus_write is high.
REQ-011 bus_data_out  output  8  write data; valid whenever bus_write is high.
REQ-012 bus_data_in  input  8  read data; valid in a cycle where bus_read=1 and bus_wait=0.
REQ-013 bus_read  output  1  read request, level-held until completion.
REQ-014 bus_write  output  1  write request, level-held until completion.
REQ-015 bus_wait  input  1  high = responder not yet done; low with a request = transfer complete this cycle.

Function
REQ-016 States SHALL be IDLE, RD, RD_GAP, WR, WR_GAP, FIN; the block is an initiator on the same 8-bit-data/16-bit-address bus as the CPU.
REQ-017 IDLE: start=1 SHALL capture src, dst, length into internal registers and go to RD if length!=0, else to FIN.
REQ-018 RD: bus_read=1, bus_address_out=current src; when bus_wait=0 the block SHALL latch bus_data_in into a byte register and go to RD_GAP.
REQ-019 RD_GAP: bus_read=bus_write=0 for exactly one cycle, then WR; this gap guarantees the responder's registered completion clears before the next request.
REQ-020 WR: bus_write=1, bus_address_out=current dst, bus_data_out=latched byte; when bus_wait=0 go to WR_GAP.
REQ-021 WR_GAP: no request for exactly one cycle; src and dst SHALL each increment by 1 and remaining count decrement by 1; then RD if remaining count !=0, else FIN.
REQ-022 FIN: done=1 for exactly one cycle, then IDLE.
REQ-023 bus_read and bus_write SHALL never be high in the same cycle.
REQ-024 Address, data and request outputs SHALL be stable for every cycle a request is held with bus_wait=1.
REQ-025 Address increments SHALL wrap modulo 2^16 (16'hFFFF -> 16'h0000) independently for src and dst.
REQ-026 Latency: start accepted at cycle 0 -> bus_read high at cycle 1; with a responder completing on the second request cycle, each byte SHALL take exactly 6 cycles (RD 2, RD_GAP 1, WR 2, WR_GAP 1).
REQ-027 start while busy or in FIN SHALL be ignored, with no change to captured operands.
REQ-028 length=0 SHALL produce no bus activity and a done pulse at cycle 1 after start.
REQ-029 Overlapping src/dst ranges SHALL be copied strictly byte-by-byte in ascending order; no hazard handling.
REQ-030 bus_wait held high indefinitely SHALL stall the block in RD or WR with no timeout.
REQ-031 bus_wait low in a cycle with no request SHALL be ignored.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, bus_read=0, bus_write=0, bus_address_out=0, bus_data_out=0, counters and captured operands to 0.
REQ-033 Reset mid-transfer (including while a request is held) SHALL abort immediately, drop the request in the next cycle, and produce no done pulse.
REQ-034 First accepted start SHALL be the first start sampled high in a cycle with rst_n=1.

Verification
REQ-035 Copy: memory 0x0100..0x0102 = 0x3E,0x03,0x26; start src=0x0100 dst=0x0200 len=3 -> 0x0200..0x0202 = 0x3E,0x03,0x26, done at cycle 19, busy high cycles 1-19.
REQ-036 Zero length: start len=0 -> no bus_read/bus_write ever, done=1 at cycle 1 only.
REQ-037 Wrap: src=0xFFFF dst=0x7FFF len=2 -> reads 0xFFFF then 0x0000, writes 0x7FFF then 0x8000.
REQ-038 Wait stretch: responder holds bus_wait=1 for 5 cycles on the first read -> bus_read and bus_address_out stable throughout, correct byte written, total latency +4 cycles vs REQ-035.
REQ-039 Busy start: second start (src=0x0000) during a len=2 copy -> ignored, original addresses used, single done pulse.
REQ-040 Reset abort: rst_n=0 during WR of byte 1 -> bus_write=0 next cycle, busy=0, no done; new start afterwards completes normally.
